mmio_periph: RTL and testbench

Parametrised memory-mapped I/O peripheral sitting between the CPU data port and data BRAM port A. It decodes a configurable I/O window, blocks BRAM writes inside that window, and muxes I/O read data onto the CPU read bus. It generalises the single switch/LED register to NUM_OUT output registers and NUM_IN synchronised input channels. It adds sticky change detection, a compare/auto-reload timer and an interrupt line.

---
 rtl/mmio_periph_if.sv | 30 +++
 rtl/mmio_periph.sv | 158 +++++++++++++++
 tb/tb_mmio_periph.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_periph_if.sv
// ============================================================================
// Module   : mmio_periph_if
// Purpose  : CPU data-port / BRAM port-A bundle seen by mmio_periph.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mmio_periph_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] cpu_addr;
    logic [WIDTH-1:0] cpu_wdata;
    logic             cpu_we;
    logic [WIDTH-1:0] cpu_rdata;
    logic [WIDTH-1:0] mem_q;
    logic             mem_we;

    // The master side is the CPU together with the BRAM read-data return.
    modport master (
        output cpu_addr, cpu_wdata, cpu_we, mem_q,
        input  cpu_rdata, mem_we
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, mem_q,
        output cpu_rdata, mem_we
    );
endinterface

`default_nettype wire

// File: rtl/mmio_periph.sv
// ============================================================================
// Module   : mmio_periph
// Purpose  : I/O window decode, output/input registers, sticky change flags,
//            compare/auto-reload timer and level interrupt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mmio_periph #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] IO_BASE = 16'h0300,
    parameter logic [WIDTH-1:0] IO_MASK = 16'h03F0,
    parameter int               NUM_OUT = 2,
    parameter int               OUT_W   = 10,
    parameter int               NUM_IN  = 1,
    parameter int               IN_W    = 10
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    mmio_periph_if.slave                  bus,
    input  wire logic [NUM_IN*IN_W-1:0]   in_bus,
    output logic      [NUM_OUT*OUT_W-1:0] out_bus,
    output logic                          irq
);

    localparam logic [3:0] c_OFF_IN   = 4'd8;
    localparam logic [3:0] c_OFF_CHG  = 4'd12;
    localparam logic [3:0] c_OFF_TCNT = 4'd13;
    localparam logic [3:0] c_OFF_TCMP = 4'd14;
    localparam logic [3:0] c_OFF_CTRL = 4'd15;

    logic                     w_io_sel;
    logic [3:0]               w_off;
    logic                     w_io_wr;
    logic [WIDTH-1:0]         w_io_rdata;

    logic [OUT_W-1:0]         r_out [NUM_OUT];
    logic [NUM_IN*IN_W-1:0]   r_s1;
    logic [NUM_IN*IN_W-1:0]   r_s2;
    logic [NUM_IN*IN_W-1:0]   r_s3;
    logic [NUM_IN-1:0]        r_chg;
    logic [NUM_IN-1:0]        w_chg_set;
    logic [NUM_IN-1:0]        w_chg_clr;

    logic [WIDTH-1:0]         r_tcnt;
    logic [WIDTH-1:0]         r_tcmp;
    logic                     r_ten;
    logic                     r_ie_chg;
    logic                     r_ie_tmr;
    logic                     r_match;
    logic                     w_tmr_hit;
    logic                     w_tcmp_wr;
    logic                     w_ctrl_wr;

    assign w_io_sel      = (bus.cpu_addr & IO_MASK) == IO_BASE;
    assign w_off         = bus.cpu_addr[3:0];
    assign w_io_wr       = bus.cpu_we & w_io_sel;
    assign bus.mem_we    = bus.cpu_we & ~w_io_sel;
    assign bus.cpu_rdata = w_io_sel ? w_io_rdata : bus.mem_q;

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++) r_out[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_io_wr && w_off == 4'(i)) r_out[i] <= bus.cpu_wdata[OUT_W-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out_bus
            assign out_bus[gi*OUT_W +: OUT_W] = r_out[gi];
        end
    endgenerate

    // Input synchroniser; the third stage exists only to detect edges on s2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= in_bus;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chg_set
            assign w_chg_set[gi] = r_s2[gi*IN_W +: IN_W] != r_s3[gi*IN_W +: IN_W];
        end
    endgenerate

    assign w_chg_clr = (w_io_wr && w_off == c_OFF_CHG) ? bus.cpu_wdata[NUM_IN-1:0] : '0;

    // A new change on the same edge as a W1C clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) r_chg <= '0;
        else       r_chg <= (r_chg & ~w_chg_clr) | w_chg_set;
    end

    // Timer: the hit is evaluated against the old TCMP, so a simultaneous
    // TCMP write still latches MATCH from the previous compare value.
    assign w_tmr_hit = r_ten && (r_tcnt == r_tcmp);
    assign w_tcmp_wr = w_io_wr && (w_off == c_OFF_TCMP);
    assign w_ctrl_wr = w_io_wr && (w_off == c_OFF_CTRL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt   <= '0;
            r_tcmp   <= '0;
            r_ten    <= 1'b0;
            r_ie_chg <= 1'b0;
            r_ie_tmr <= 1'b0;
            r_match  <= 1'b0;
        end else begin
            if (w_tmr_hit || w_tcmp_wr) r_tcnt <= '0;
            else if (r_ten)             r_tcnt <= r_tcnt + 1'b1;

            if (w_tcmp_wr) r_tcmp <= bus.cpu_wdata;

            if (w_tmr_hit)                         r_match <= 1'b1;
            else if (w_ctrl_wr && bus.cpu_wdata[3]) r_match <= 1'b0;

            if (w_ctrl_wr) begin
                r_ten    <= bus.cpu_wdata[0];
                r_ie_chg <= bus.cpu_wdata[1];
                r_ie_tmr <= bus.cpu_wdata[2];
            end
        end
    end

    // Register read mux; anything not matched reads zero.
    always_comb begin
        w_io_rdata = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (w_off == 4'(i)) w_io_rdata[OUT_W-1:0] = r_out[i];
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_off == c_OFF_IN + 4'(i)) w_io_rdata[IN_W-1:0] = r_s2[i*IN_W +: IN_W];
        end
        case (w_off)
            c_OFF_CHG:  w_io_rdata[NUM_IN-1:0] = r_chg;
            c_OFF_TCNT: w_io_rdata             = r_tcnt;
            c_OFF_TCMP: w_io_rdata             = r_tcmp;
            c_OFF_CTRL: w_io_rdata[3:0]        = {r_match, r_ie_tmr, r_ie_chg, r_ten};
            default:    ;
        endcase
    end

    assign irq = ((|r_chg) & r_ie_chg) | (r_match & r_ie_tmr);

endmodule

`default_nettype wire

// File: tb/tb_mmio_periph.sv
// ============================================================================
// Module   : tb_mmio_periph
// Purpose  : Directed and randomised checks of mmio_periph against a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mmio_periph;

    localparam int WIDTH   = 16;
    localparam int NUM_OUT = 2;
    localparam int OUT_W   = 10;
    localparam int NUM_IN  = 1;
    localparam int IN_W    = 10;

    logic clk;
    logic reset;
    logic [NUM_IN*IN_W-1:0]   in_bus;
    logic [NUM_OUT*OUT_W-1:0] out_bus;
    logic                     irq;

    mmio_periph_if #(.WIDTH(WIDTH)) bus ();

    mmio_periph #(
        .WIDTH(WIDTH), .IO_BASE(16'h0300), .IO_MASK(16'h03F0),
        .NUM_OUT(NUM_OUT), .OUT_W(OUT_W), .NUM_IN(NUM_IN), .IN_W(IN_W)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .in_bus(in_bus), .out_bus(out_bus), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [OUT_W-1:0]       m_out [NUM_OUT];
    logic [NUM_IN*IN_W-1:0] m_pin_hist [3];   // pin samples of the last three edges, [2] newest
    logic [NUM_IN-1:0]      m_chg;
    logic [15:0]            m_tcnt, m_tcmp;
    logic                   m_ten, m_ie_chg, m_ie_tmr, m_match;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_io(input logic [15:0] a);
        return (a & 16'h03F0) == 16'h0300;
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a, input logic [15:0] q);
        logic [15:0] r;
        int          off;
        if (!is_io(a)) return q;
        off = int'(a[3:0]);
        r   = '0;
        if (off < NUM_OUT)                      r = 16'(m_out[off]);
        else if (off >= 8 && off < 8 + NUM_IN)  r = 16'(m_pin_hist[1][(off-8)*IN_W +: IN_W]);
        else if (off == 12)                     r = 16'(m_chg);
        else if (off == 13)                     r = m_tcnt;
        else if (off == 14)                     r = m_tcmp;
        else if (off == 15)                     r = {12'h0, m_match, m_ie_tmr, m_ie_chg, m_ten};
        return r;
    endfunction

    function automatic logic [NUM_OUT*OUT_W-1:0] model_out_bus();
        logic [NUM_OUT*OUT_W-1:0] v;
        for (int i = 0; i < NUM_OUT; i++) v[i*OUT_W +: OUT_W] = m_out[i];
        return v;
    endfunction

    function automatic logic model_irq();
        return ((|m_chg) & m_ie_chg) | (m_match & m_ie_tmr);
    endfunction

    // Applies one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic              wr;
        int                off;
        logic              hit;
        logic [NUM_IN-1:0] chg_new;
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++) m_out[i] = '0;
            for (int i = 0; i < 3; i++) m_pin_hist[i] = '0;
            m_chg = '0; m_tcnt = '0; m_tcmp = '0;
            m_ten = 0; m_ie_chg = 0; m_ie_tmr = 0; m_match = 0;
            return;
        end
        wr  = bus.cpu_we && is_io(bus.cpu_addr);
        off = int'(bus.cpu_addr[3:0]);
        for (int i = 0; i < NUM_IN; i++)
            chg_new[i] = m_pin_hist[1][i*IN_W +: IN_W] != m_pin_hist[0][i*IN_W +: IN_W];
        if (wr && off == 12) m_chg = m_chg & ~bus.cpu_wdata[NUM_IN-1:0];
        m_chg = m_chg | chg_new;
        hit = m_ten && (m_tcnt == m_tcmp);
        if (hit || (wr && off == 14)) m_tcnt = 16'h0;
        else if (m_ten)               m_tcnt = m_tcnt + 16'h1;
        if (hit) m_match = 1'b1;
        else if (wr && off == 15 && bus.cpu_wdata[3]) m_match = 1'b0;
        if (wr && off == 14) m_tcmp = bus.cpu_wdata;
        if (wr && off == 15) {m_ie_tmr, m_ie_chg, m_ten} = bus.cpu_wdata[2:0];
        if (wr && off < NUM_OUT) m_out[off] = bus.cpu_wdata[OUT_W-1:0];
        m_pin_hist[0] = m_pin_hist[1];
        m_pin_hist[1] = m_pin_hist[2];
        m_pin_hist[2] = in_bus;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("out_bus", 32'(out_bus), 32'(model_out_bus()));
        check("irq", 32'(irq), 32'(model_irq()));
    endtask

    task automatic rd(input logic [15:0] a);
        bus.cpu_addr = a;
        bus.cpu_we   = 1'b0;
        #1;
        check("rdata", 32'(bus.cpu_rdata), 32'(model_read(a, bus.mem_q)));
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_we    = 1'b1;
        #1;
        check("mem_we", 32'(bus.mem_we), 32'(!is_io(a)));
        tick();
        bus.cpu_we = 1'b0;
    endtask

    task automatic idle();
        bus.cpu_addr  = 16'h0000;
        bus.cpu_wdata = 16'h0000;
        bus.cpu_we    = 1'b0;
        tick();
    endtask

    int exp_seq [5] = '{1, 2, 3, 4, 0};

    initial begin
        reset = 1'b1;
        in_bus = '0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_we = 1'b0; bus.mem_q = 16'hA5A5;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("rst_out_bus", 32'(out_bus), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rd(16'h030D); check("rst_tcnt", 32'(bus.cpu_rdata), 32'h0);
        rd(16'h030F); check("rst_ctrl", 32'(bus.cpu_rdata), 32'h0);

        // OUT[0] write is blocked from BRAM and reads back
        wr(16'h0300, 16'h03FF);
        check("out0_val", 32'(out_bus[9:0]), 32'h3FF);
        rd(16'h0300); check("out0_read", 32'(bus.cpu_rdata), 32'h03FF);
        wr(16'h0301, 16'hFC15);
        rd(16'h0301); check("out1_read", 32'(bus.cpu_rdata), 32'h0015);

        // Input synchronisation and change detection
        in_bus = 10'h155;
        idle(); rd(16'h0308); check("in_1edge", 32'(bus.cpu_rdata), 32'h0);
        idle(); rd(16'h0308); check("in_2edge", 32'(bus.cpu_rdata), 32'h0155);
        idle(); rd(16'h030C); check("chg_3edge", 32'(bus.cpu_rdata), 32'h1);
        wr(16'h030F, 16'h0002);
        check("irq_chg", 32'(irq), 32'h1);

        // W1C clear colliding with a new change: set wins
        in_bus = 10'h0AA;
        idle(); idle();
        wr(16'h030C, 16'h0001);
        rd(16'h030C); check("chg_set_wins", 32'(bus.cpu_rdata), 32'h1);
        idle();
        wr(16'h030C, 16'h0001);
        rd(16'h030C); check("chg_cleared", 32'(bus.cpu_rdata), 32'h0);
        check("irq_cleared", 32'(irq), 32'h0);

        // Timer with TCMP = 4
        wr(16'h030E, 16'h0004);
        wr(16'h030F, 16'h0005);
        for (int k = 0; k < 5; k++) begin
            idle();
            rd(16'h030D); check("tcnt_seq", 32'(bus.cpu_rdata), 32'(exp_seq[k]));
        end
        rd(16'h030F); check("match_set", 32'(bus.cpu_rdata), 32'h000D);
        check("irq_tmr", 32'(irq), 32'h1);
        wr(16'h030F, 16'h000D);
        rd(16'h030F); check("match_clr", 32'(bus.cpu_rdata), 32'h0005);
        check("irq_tmr_clr", 32'(irq), 32'h0);

        // Memory pass-through and unmapped I/O offset
        bus.mem_q = 16'hBEEF;
        wr(16'h0050, 16'h1234);
        rd(16'h0050); check("mem_read", 32'(bus.cpu_rdata), 32'hBEEF);
        rd(16'h0306); check("unmapped", 32'(bus.cpu_rdata), 32'h0);

        // Reset mid-operation with a pin held high through release
        in_bus = 10'h3FF;
        idle(); idle(); idle();
        reset = 1'b1;
        idle();
        reset = 1'b0;
        check("rst2_out_bus", 32'(out_bus), 32'h0);
        check("rst2_irq", 32'(irq), 32'h0);
        rd(16'h030F); check("rst2_ctrl", 32'(bus.cpu_rdata), 32'h0);
        rd(16'h030C); check("rst2_chg", 32'(bus.cpu_rdata), 32'h0);
        idle(); idle();
        rd(16'h030C); check("chg_pre3", 32'(bus.cpu_rdata), 32'h0);
        idle();
        rd(16'h030C); check("chg_post3", 32'(bus.cpu_rdata), 32'h1);
        rd(16'h030D); check("tcnt_held", 32'(bus.cpu_rdata), 32'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) != 0) bus.cpu_addr = 16'h0300 | 16'($urandom_range(0, 15));
            else                           bus.cpu_addr = 16'($urandom);
            bus.cpu_we    = 1'($urandom_range(0, 1));
            bus.cpu_wdata = 16'($urandom);
            if (bus.cpu_addr[3:0] == 4'd14) bus.cpu_wdata = 16'($urandom_range(0, 7));
            bus.mem_q = 16'($urandom);
            if ($urandom_range(0, 5) == 0) in_bus = 10'($urandom);
            #1;
            check("rnd_rdata", 32'(bus.cpu_rdata), 32'(model_read(bus.cpu_addr, bus.mem_q)));
            check("rnd_mem_we", 32'(bus.mem_we), 32'(bus.cpu_we && !is_io(bus.cpu_addr)));
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
